// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings and
// configuration-select codes.
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_REQ  = 2'd1,
      IRQ_SERV = 2'd2
   } irq_state_e;

   typedef enum logic [1:0] {
      CFG_MASK = 2'b00,
      CFG_W1C  = 2'b01,
      CFG_W1S  = 2'b10,
      CFG_NOP  = 2'b11
   } cfg_sel_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; index is zero-extended to IDX_W bits.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int IDX_W   = 3
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of the core's single interrupt input.
// Define IRQ_SYNC_EN to pass irq_src through a two-flop synchronizer.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC   = 8,
   parameter int VEC_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_SRC-1:0]   irq_src,
   input  logic                 cfg_wr_en,
   input  logic [1:0]           cfg_sel,
   input  logic [NUM_SRC-1:0]   cfg_wdata,
   input  logic                 ps_irq_ack,
   input  logic                 ps_irq_rti,
   output logic                 interrupt,
   output logic [VEC_WIDTH-1:0] irq_vec,
   output logic [NUM_SRC-1:0]   irq_mask,
   output logic [NUM_SRC-1:0]   irq_pend,
   output logic                 irq_active
);

   logic [NUM_SRC-1:0]   src_s;
   logic [NUM_SRC-1:0]   src_prev;
   logic [NUM_SRC-1:0]   src_rise;
   logic [NUM_SRC-1:0]   pend_q;
   logic [NUM_SRC-1:0]   pend_d;
   logic [NUM_SRC-1:0]   pend_no_ack;
   logic [NUM_SRC-1:0]   mask_q;
   logic [NUM_SRC-1:0]   w1c_bits;
   logic [NUM_SRC-1:0]   w1s_bits;
   logic [NUM_SRC-1:0]   ack_bits;
   logic [NUM_SRC-1:0]   cand;
   logic                 mask_wr;
   logic                 cand_valid;
   logic [VEC_WIDTH-1:0] winner;
   logic [VEC_WIDTH-1:0] irq_vec_q;
   logic [VEC_WIDTH-1:0] irq_vec_d;
   logic                 ack_take;
   logic                 withdraw;
   irq_state_e           state_q;
   irq_state_e           state_d;
   cfg_sel_e             sel;

`ifdef IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync_q1;
   logic [NUM_SRC-1:0] sync_q2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_src;
         sync_q2 <= sync_q1;
      end
   end

   assign src_s = sync_q2;
`else
   assign src_s = irq_src;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src_prev <= '0;
      end else begin
         src_prev <= src_s;
      end
   end

   assign src_rise = src_s & ~src_prev;

   assign sel      = cfg_sel_e'(cfg_sel);
   assign mask_wr  = cfg_wr_en && (sel == CFG_MASK);
   assign w1c_bits = (cfg_wr_en && (sel == CFG_W1C)) ? cfg_wdata : '0;
   assign w1s_bits = (cfg_wr_en && (sel == CFG_W1S)) ? cfg_wdata : '0;

   assign ack_take = (state_q == IRQ_REQ) && ps_irq_ack;
   assign ack_bits = ack_take ? (NUM_SRC'(1) << irq_vec_q) : '0;

   // Sets (edge or W1S) dominate clears; pend_no_ack leaves out the ack clear
   // so the withdraw decision does not loop back through the FSM.
   assign pend_no_ack = src_rise | w1s_bits | (pend_q & ~w1c_bits);
   assign pend_d      = src_rise | w1s_bits | (pend_q & ~(w1c_bits | ack_bits));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
         mask_q <= '1;
      end else begin
         pend_q <= pend_d;
         if (mask_wr) begin
            mask_q <= cfg_wdata;
         end
      end
   end

   assign cand = pend_q & ~mask_q;

   irq_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (VEC_WIDTH)
   ) u_prio_enc (
      .req   (cand),
      .valid (cand_valid),
      .idx   (winner)
   );

   assign withdraw = !pend_no_ack[irq_vec_q] || mask_q[irq_vec_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IRQ_IDLE;
         irq_vec_q <= '0;
      end else begin
         state_q   <= state_d;
         irq_vec_q <= irq_vec_d;
      end
   end

   // The vector is captured only on leaving IDLE and stays frozen through
   // REQ and SERV, so later arrivals never preempt the one being serviced.
   always_comb begin
      state_d   = state_q;
      irq_vec_d = irq_vec_q;
      case (state_q)
         IRQ_IDLE: begin
            if (cand_valid) begin
               state_d   = IRQ_REQ;
               irq_vec_d = winner;
            end
         end
         IRQ_REQ: begin
            if (ack_take) begin
               state_d = IRQ_SERV;
            end else if (withdraw) begin
               state_d = IRQ_IDLE;
            end
         end
         IRQ_SERV: begin
            if (ps_irq_rti) begin
               state_d = IRQ_IDLE;
            end
         end
         default: begin
            state_d = IRQ_IDLE;
         end
      endcase
   end

   assign interrupt  = (state_q == IRQ_REQ);
   assign irq_active = (state_q == IRQ_SERV);
   assign irq_vec    = irq_vec_q;
   assign irq_mask   = mask_q;
   assign irq_pend   = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: request launches are scoreboarded (vector and arrival cycle),
// register state is checked directly after each directed step.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   localparam int NUM_SRC   = 8;
   localparam int VEC_WIDTH = 3;
`ifdef IRQ_SYNC_EN
   localparam int SRC_LAT = 4;
`else
   localparam int SRC_LAT = 2;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NUM_SRC-1:0]   irq_src = '0;
   logic                 cfg_wr_en = 1'b0;
   logic [1:0]           cfg_sel = CFG_NOP;
   logic [NUM_SRC-1:0]   cfg_wdata = '0;
   logic                 ps_irq_ack = 1'b0;
   logic                 ps_irq_rti = 1'b0;
   logic                 interrupt;
   logic [VEC_WIDTH-1:0] irq_vec;
   logic [NUM_SRC-1:0]   irq_mask;
   logic [NUM_SRC-1:0]   irq_pend;
   logic                 irq_active;

   typedef struct {
      logic [VEC_WIDTH-1:0] vec;
      int                   due;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic int_prev = 1'b0;

   irq_ctrl #(
      .NUM_SRC   (NUM_SRC),
      .VEC_WIDTH (VEC_WIDTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_src    (irq_src),
      .cfg_wr_en  (cfg_wr_en),
      .cfg_sel    (cfg_sel),
      .cfg_wdata  (cfg_wdata),
      .ps_irq_ack (ps_irq_ack),
      .ps_irq_rti (ps_irq_rti),
      .interrupt  (interrupt),
      .irq_vec    (irq_vec),
      .irq_mask   (irq_mask),
      .irq_pend   (irq_pend),
      .irq_active (irq_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every rising edge of interrupt must match the oldest expected request.
   always @(negedge clk) begin
      exp_t e;
      if (interrupt && !int_prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_irq: got vec %0d at cycle %0d, expected no request", irq_vec, cyc);
         end else begin
            e = exp_q.pop_front();
            if (irq_vec !== e.vec || cyc != e.due) begin
               errors++;
               $display("[TB] FAIL irq_req: got vec %0d at cycle %0d, expected vec %0d at cycle %0d",
                        irq_vec, cyc, e.vec, e.due);
            end
         end
      end
      int_prev = interrupt;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic expect_irq(input logic [VEC_WIDTH-1:0] vec, input int due);
      exp_t e;
      e.vec = vec;
      e.due = due;
      exp_q.push_back(e);
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [NUM_SRC-1:0] data);
      cfg_wr_en = 1'b1;
      cfg_sel   = sel;
      cfg_wdata = data;
      tick(1);
      cfg_wr_en = 1'b0;
      cfg_sel   = CFG_NOP;
      cfg_wdata = '0;
   endtask

   task automatic apply_stimulus(input logic [NUM_SRC-1:0] bits, output int n);
      n = cyc;
      irq_src = bits;
      tick(1);
      irq_src = '0;
   endtask

   task automatic pulse_ack();
      ps_irq_ack = 1'b1;
      tick(1);
      ps_irq_ack = 1'b0;
   endtask

   task automatic pulse_rti();
      ps_irq_rti = 1'b1;
      tick(1);
      ps_irq_rti = 1'b0;
   endtask

   task automatic wait_irq(input string name);
      for (int k = 0; k < 20 && !interrupt; k++) tick(1);
      checks++;
      if (!interrupt) begin
         errors++;
         $display("[TB] FAIL %s: got interrupt 0 after 20 cycles, expected 1", name);
      end
   endtask

   initial begin
      int n;
      int m;

      // Reset values
      tick(3);
      check_output("rst_interrupt", 32'(interrupt), 32'h0);
      check_output("rst_vec", 32'(irq_vec), 32'h0);
      check_output("rst_pend", 32'(irq_pend), 32'h0);
      check_output("rst_mask", 32'(irq_mask), 32'hFF);
      check_output("rst_active", 32'(irq_active), 32'h0);
      reset = 1'b1;
      tick(2);

      // 1: single source, full ack/rti round trip
      cfg_write(CFG_MASK, 8'h00);
      check_output("t1_mask", 32'(irq_mask), 32'h00);
      apply_stimulus(8'h08, n);
      expect_irq(3'd3, n + SRC_LAT);
      wait_irq("t1_wait");
      check_output("t1_vec", 32'(irq_vec), 32'h3);
      pulse_ack();
      check_output("t1_pend_after_ack", 32'(irq_pend), 32'h00);
      check_output("t1_active", 32'(irq_active), 32'h1);
      check_output("t1_int_after_ack", 32'(interrupt), 32'h0);
      pulse_rti();
      check_output("t1_active_after_rti", 32'(irq_active), 32'h0);

      // 2: simultaneous edges, lower index wins, the other follows at rti+2
      apply_stimulus(8'h24, n);
      expect_irq(3'd2, n + SRC_LAT);
      wait_irq("t2_wait_a");
      check_output("t2_vec_a", 32'(irq_vec), 32'h2);
      pulse_ack();
      check_output("t2_pend_mid", 32'(irq_pend), 32'h20);
      m = cyc;
      expect_irq(3'd5, m + 2);
      pulse_rti();
      wait_irq("t2_wait_b");
      check_output("t2_vec_b", 32'(irq_vec), 32'h5);
      pulse_ack();
      pulse_rti();
      check_output("t2_pend_end", 32'(irq_pend), 32'h00);

      // 3: masked source latches but does not request until unmasked
      cfg_write(CFG_MASK, 8'hFF);
      apply_stimulus(8'h02, n);
      tick(SRC_LAT + 1);
      check_output("t3_pend", 32'(irq_pend), 32'h02);
      check_output("t3_int_masked", 32'(interrupt), 32'h0);
      m = cyc;
      expect_irq(3'd1, m + 2);
      cfg_write(CFG_MASK, 8'h00);
      wait_irq("t3_wait");
      check_output("t3_vec", 32'(irq_vec), 32'h1);
      pulse_ack();
      pulse_rti();

      // 4: withdraw by W1C, then W1C coinciding with ack
      apply_stimulus(8'h10, n);
      expect_irq(3'd4, n + SRC_LAT);
      wait_irq("t4_wait_a");
      cfg_write(CFG_W1C, 8'h10);
      check_output("t4_int_withdrawn", 32'(interrupt), 32'h0);
      check_output("t4_pend_withdrawn", 32'(irq_pend), 32'h00);
      check_output("t4_active_withdrawn", 32'(irq_active), 32'h0);
      tick(2);
      check_output("t4_int_stays_idle", 32'(interrupt), 32'h0);
      apply_stimulus(8'h10, n);
      expect_irq(3'd4, n + SRC_LAT);
      wait_irq("t4_wait_b");
      cfg_wr_en  = 1'b1;
      cfg_sel    = CFG_W1C;
      cfg_wdata  = 8'h10;
      ps_irq_ack = 1'b1;
      tick(1);
      cfg_wr_en  = 1'b0;
      cfg_sel    = CFG_NOP;
      cfg_wdata  = '0;
      ps_irq_ack = 1'b0;
      check_output("t4_active_ack_wins", 32'(irq_active), 32'h1);
      check_output("t4_pend_ack_wins", 32'(irq_pend), 32'h00);
      pulse_rti();

      // 5: no nesting during service, then reset mid-service
      apply_stimulus(8'h04, n);
      expect_irq(3'd2, n + SRC_LAT);
      wait_irq("t5_wait");
      pulse_ack();
      apply_stimulus(8'h01, n);
      tick(SRC_LAT + 1);
      check_output("t5_pend_in_serv", 32'(irq_pend), 32'h01);
      check_output("t5_int_in_serv", 32'(interrupt), 32'h0);
      check_output("t5_active_in_serv", 32'(irq_active), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check_output("t5_rst_interrupt", 32'(interrupt), 32'h0);
      check_output("t5_rst_vec", 32'(irq_vec), 32'h0);
      check_output("t5_rst_pend", 32'(irq_pend), 32'h00);
      check_output("t5_rst_mask", 32'(irq_mask), 32'hFF);
      check_output("t5_rst_active", 32'(irq_active), 32'h0);
      tick(2);
      reset = 1'b1;
      cfg_write(CFG_MASK, 8'h00);
      tick(3);
      check_output("t5_no_survivor_int", 32'(interrupt), 32'h0);
      check_output("t5_no_survivor_pend", 32'(irq_pend), 32'h00);
      pulse_ack();
      check_output("t5_stray_ack", 32'(irq_active), 32'h0);

      // 6: set beats clear, held levels do not retrigger, W1S and unmask
      cfg_write(CFG_MASK, 8'hFF);
      irq_src = 8'h40;
      repeat (SRC_LAT - 2) tick(1);
      cfg_write(CFG_W1C, 8'h40);
      check_output("t6_set_beats_clear", 32'(irq_pend), 32'h40);
      cfg_write(CFG_W1C, 8'h40);
      tick(3);
      check_output("t6_level_no_retrigger", 32'(irq_pend), 32'h00);
      irq_src = '0;
      cfg_write(CFG_W1S, 8'h81);
      check_output("t6_w1s", 32'(irq_pend), 32'h81);
      cfg_write(CFG_W1C, 8'h01);
      check_output("t6_w1c", 32'(irq_pend), 32'h80);
      check_output("t6_int_masked", 32'(interrupt), 32'h0);
      m = cyc;
      expect_irq(3'd7, m + 2);
      cfg_write(CFG_MASK, 8'h7F);
      wait_irq("t6_wait");
      check_output("t6_vec", 32'(irq_vec), 32'h7);
      pulse_ack();
      check_output("t6_pend_end", 32'(irq_pend), 32'h00);
      pulse_rti();

      tick(4);
      check_output("exp_queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
